// File: rtl/uart_stream_if.sv
// Avalon-MM link between the stream bridge (master) and the UART register port (slave).
interface uart_stream_if #(
    parameter int unsigned ADW = 32
);
    logic           uart_read;
    logic           uart_write;
    logic [ADW-1:0] uart_writedata;
    logic [ADW-1:0] uart_readdata;
    logic           uart_waitrequest;
    logic           uart_interrupt;

    modport master (
        output uart_read, uart_write, uart_writedata,
        input  uart_readdata, uart_waitrequest, uart_interrupt
    );

    modport slave (
        input  uart_read, uart_write, uart_writedata,
        output uart_readdata, uart_waitrequest, uart_interrupt
    );
endinterface

// File: rtl/uart_stream.sv
// Bridges a byte stream pair onto a UART Avalon register port: one-entry TX holding
// register and an RX FIFO carrying the UART overrun/parity flags with each byte.
module uart_stream #(
    parameter int unsigned BYTESIZE = 8,
    parameter string       PARITY   = "NONE",
    parameter int unsigned ADW      = 32,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    input  logic [BYTESIZE-1:0]    tx_data,
    output logic                   tx_ready,
    output logic                   rx_valid,
    output logic [BYTESIZE-1:0]    rx_data,
    output logic                   rx_err,
    output logic                   rx_prt,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] rx_level,
    uart_stream_if.master          uart
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   LW        = AW + 1;
    localparam int unsigned   EW        = BYTESIZE + 2;
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);
    localparam bit            HasParity = (PARITY != "NONE");

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e state_q, state_d;

    logic                hold_full_q, hold_full_d;
    logic [BYTESIZE-1:0] hold_data_q;
    logic                hold_load, hold_clear;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic                fifo_full, rx_push, rx_pop, prt_bit;
    logic [EW-1:0]       push_entry, head;
    logic                unused_readdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state: a pending character beats a pending TX byte
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (uart.uart_interrupt && !fifo_full)             state_d = StRead;
                else if (hold_full_q && !uart.uart_waitrequest)    state_d = StWrite;
            end
            StRead:  state_d = StIdle;
            StWrite: if (!uart.uart_waitrequest) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs
    always_comb begin
        uart.uart_read      = 1'b0;
        uart.uart_write     = 1'b0;
        uart.uart_writedata = '0;
        unique case (state_q)
            StRead:  uart.uart_read = 1'b1;
            StWrite: begin
                uart.uart_write     = 1'b1;
                uart.uart_writedata = ADW'(hold_data_q);
            end
            default: ;
        endcase
    end

    // TX holding register; tx_ready is low while full, so load and clear never collide
    assign tx_ready   = !hold_full_q && !rst;
    assign hold_load  = tx_valid && tx_ready;
    assign hold_clear = (state_q == StWrite) && !uart.uart_waitrequest;

    always_comb begin
        hold_full_d = hold_full_q;
        if (hold_load)       hold_full_d = 1'b1;
        else if (hold_clear) hold_full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) hold_full_q <= 1'b0;
        else     hold_full_q <= hold_full_d;
        if (hold_load) hold_data_q <= tx_data;
    end

    // RX FIFO; only reads that return a character (rdy set) are stored
    assign prt_bit    = HasParity ? uart.uart_readdata[ADW-3] : 1'b0;
    assign push_entry = {prt_bit, uart.uart_readdata[ADW-2], uart.uart_readdata[BYTESIZE-1:0]};
    assign rx_push    = (state_q == StRead) && uart.uart_readdata[ADW-1];
    assign rx_pop     = rx_valid && rx_ready;
    assign fifo_full  = (level_q == FullLevel);

    always_comb begin
        level_d = level_q;
        if (rx_push && !rx_pop)      level_d = level_q + LW'(1);
        else if (!rx_push && rx_pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rx_push) mem_q[wptr_q] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (rx_push) wptr_q <= wptr_q + AW'(1);
            if (rx_pop)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    assign head     = mem_q[rptr_q];
    assign rx_valid = (level_q != '0);
    assign rx_data  = head[BYTESIZE-1:0];
    assign rx_err   = head[BYTESIZE];
    assign rx_prt   = head[BYTESIZE+1];
    assign rx_level = level_q;

    assign unused_readdata = ^uart.uart_readdata;

endmodule
